// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//
// Serialises 16-bit unsigned samples to an external SPI DAC (mode 0, MSB
// first) as 24-bit frames: the DAC_CMD byte followed by the 16 sample bits.
// A one-entry holding register accepts the next sample while the current
// frame is shifting, so frames can run back to back.
//
// Ports:
//   i_clk       synth clock; all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_data      unsigned sample
//   i_valid     i_data valid this cycle
//   o_ready     holding register empty; sample taken on i_valid && o_ready
//   o_dac_cs_n  DAC chip select, active low
//   o_dac_sclk  DAC serial clock, idles low
//   o_dac_mosi  DAC serial data, MSB first
//   o_busy      high from CS_N falling until the inter-frame gap expires
//   o_underrun  one-cycle pulse when a gap ends with no sample held
// -----------------------------------------------------------------------------
module dac_spi_tx #(
   parameter int unsigned CLK_DIV = 2,      // i_clk cycles per SCLK half-period
   parameter int unsigned CS_GAP  = 2,      // i_clk cycles CS_N stays high
   parameter logic [7:0]  DAC_CMD = 8'h30   // frame bits [23:16]
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_dac_cs_n,
   output logic        o_dac_sclk,
   output logic        o_dac_mosi,
   output logic        o_busy,
   output logic        o_underrun
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
   localparam logic [4:0] LAST_BIT = 5'd23;

   state_e      state_q, state_d;
   logic [15:0] hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic [23:0] shift_q, shift_d;
   logic [7:0]  cnt_q, cnt_d;        // SCLK half-period or gap counter
   logic [4:0]  bit_q, bit_d;        // rising SCLK edges completed, 0..23
   logic        sclk_q, sclk_d;
   logic        cs_n_q, cs_n_d;
   logic        mosi_q, mosi_d;
   logic        busy_q, busy_d;
   logic        underrun_q, underrun_d;
   logic        accept;

   assign accept = i_valid && !hold_full_q;

   always_comb begin
      // NOTE: every next-state signal takes its hold value before the case
      // statement so no path leaves one unassigned, which would infer latches.
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      mosi_d      = mosi_q;
      busy_d      = busy_q;
      underrun_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               shift_d     = {DAC_CMD, hold_q};
               hold_full_d = 1'b0;
               cs_n_d      = 1'b0;
               mosi_d      = DAC_CMD[7];
               sclk_d      = 1'b0;
               busy_d      = 1'b1;
               cnt_d       = '0;
               bit_d       = '0;
               state_d     = SHIFT;
            end
         end

         SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: either present the next bit or, after the
                  // 24th rising edge, close the frame with SCLK already low.
                  sclk_d = 1'b0;
                  if (bit_q == LAST_BIT) begin
                     cs_n_d  = 1'b1;
                     mosi_d  = 1'b0;
                     state_d = GAP;
                  end else begin
                     shift_d = {shift_q[22:0], 1'b0};
                     mosi_d  = shift_q[22];
                     bit_d   = bit_q + 5'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d      = '0;
               busy_d     = 1'b0;
               underrun_d = !hold_full_q;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase

      // Accept and hand-off are mutually exclusive: hand-off needs the
      // register full, accept needs it empty.
      if (accept) begin
         hold_d      = i_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value, independent of statement order.
      if (i_rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         bit_q       <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         busy_q      <= busy_d;
         underrun_q  <= underrun_d;
      end
   end

   // Ready comes straight from the flop, so it cannot rise in the same
   // cycle the held sample moves into the shifter.
   assign o_ready    = !hold_full_q;
   assign o_dac_cs_n = cs_n_q;
   assign o_dac_sclk = sclk_q;
   assign o_dac_mosi = mosi_q;
   assign o_busy     = busy_q;
   assign o_underrun = underrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_tx
//
// Two instances: A with CLK_DIV=2/CS_GAP=2 and B with CLK_DIV=1/CS_GAP=1.
// A monitor decodes the SPI pins of both into frames with timestamps; the
// main sequence drives samples and compares decoded frames against expected
// values and a frame-slot model of sample acceptance.
// -----------------------------------------------------------------------------
module tb_dac_spi_tx;

   localparam int D_A  = 2;
   localparam int G_A  = 2;
   localparam int D_B  = 1;
   localparam int G_B  = 1;
   localparam int CAP  = 64;
   localparam int UCAP = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]  rst;
   logic [1:0]  valid;
   logic [15:0] data_a, data_b;

   logic ready_a, cs_n_a, sclk_a, mosi_a, busy_a, und_a;
   logic ready_b, cs_n_b, sclk_b, mosi_b, busy_b, und_b;
   logic [1:0] ready, cs_n, sclk, mosi, busy, underrun;

   assign ready    = {ready_b, ready_a};
   assign cs_n     = {cs_n_b,  cs_n_a};
   assign sclk     = {sclk_b,  sclk_a};
   assign mosi     = {mosi_b,  mosi_a};
   assign busy     = {busy_b,  busy_a};
   assign underrun = {und_b,   und_a};

   dac_spi_tx #(.CLK_DIV(D_A), .CS_GAP(G_A), .DAC_CMD(8'h30)) dut_a (
      .i_clk(clk), .i_rst(rst[0]), .i_data(data_a), .i_valid(valid[0]),
      .o_ready(ready_a), .o_dac_cs_n(cs_n_a), .o_dac_sclk(sclk_a),
      .o_dac_mosi(mosi_a), .o_busy(busy_a), .o_underrun(und_a)
   );

   dac_spi_tx #(.CLK_DIV(D_B), .CS_GAP(G_B), .DAC_CMD(8'h30)) dut_b (
      .i_clk(clk), .i_rst(rst[1]), .i_data(data_b), .i_valid(valid[1]),
      .o_ready(ready_b), .o_dac_cs_n(cs_n_b), .o_dac_sclk(sclk_b),
      .o_dac_mosi(mosi_b), .o_busy(busy_b), .o_underrun(und_b)
   );

   // ---------------------------------------------------------------- monitor
   logic [23:0] frm   [2][CAP];
   int          fbits [2][CAP];
   int          ffall [2][CAP];
   int          frise [2][CAP];
   int          und_t [2][UCAP];
   int          nfrm     [2] = '{0, 0};
   int          nfall    [2] = '{0, 0};
   int          nund     [2] = '{0, 0};
   int          viol     [2] = '{0, 0};
   int          cur_bits [2] = '{0, 0};
   int          busy_len [2] = '{0, 0};

   initial begin
      logic [1:0]  p_cs, p_sclk, p_mosi, p_busy;
      logic [23:0] sh     [2];
      int          fall_c [2];
      int          busy_c [2];
      p_cs   = 2'b11;
      p_sclk = 2'b00;
      p_mosi = 2'b00;
      p_busy = 2'b00;
      for (int k = 0; k < 2; k++) begin
         sh[k]     = '0;
         fall_c[k] = 0;
         busy_c[k] = 0;
      end
      forever begin
         @(posedge clk);
         #2;
         for (int k = 0; k < 2; k++) begin
            if (underrun[k] === 1'b1) begin
               if (nund[k] < UCAP) und_t[k][nund[k]] = cyc;
               nund[k]++;
            end
            if (busy[k] && !p_busy[k]) busy_c[k] = cyc;
            if (!busy[k] && p_busy[k]) busy_len[k] = cyc - busy_c[k];
            if (!cs_n[k] && p_cs[k]) begin
               nfall[k]++;
               fall_c[k]   = cyc;
               cur_bits[k] = 0;
               sh[k]       = '0;
            end
            if (rst[k]) begin
               cur_bits[k] = 0;
            end else begin
               if (cs_n[k] != p_cs[k] && sclk[k]) viol[k]++;
               if (cs_n[k] && p_cs[k] && sclk[k] != p_sclk[k]) viol[k]++;
               if (mosi[k] != p_mosi[k] && !(p_sclk[k] && !sclk[k]) && cs_n[k] == p_cs[k])
                  viol[k]++;
               if (!cs_n[k] && !p_sclk[k] && sclk[k]) begin
                  sh[k] = {sh[k][22:0], mosi[k]};
                  cur_bits[k]++;
               end
               if (cs_n[k] && !p_cs[k]) begin
                  if (nfrm[k] < CAP) begin
                     frm[k][nfrm[k]]   = sh[k];
                     fbits[k][nfrm[k]] = cur_bits[k];
                     ffall[k][nfrm[k]] = fall_c[k];
                     frise[k][nfrm[k]] = cyc;
                  end
                  nfrm[k]++;
               end
            end
            p_cs[k]   = cs_n[k];
            p_sclk[k] = sclk[k];
            p_mosi[k] = mosi[k];
            p_busy[k] = busy[k];
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ready(input int d);
      int t = 0;
      while (ready[d] !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (ready[d] !== 1'b1) check("ready_timeout", 32'(ready[d]), 32'd1);
   endtask

   task automatic send(input int d, input logic [15:0] v);
      wait_ready(d);
      if (d == 0) data_a = v;
      else        data_b = v;
      valid[d] = 1'b1;
      @(negedge clk);
      valid[d] = 1'b0;
   endtask

   task automatic wait_frames(input int d, input int n);
      int t = 0;
      while (nfrm[d] < n && t < 2000) begin
         @(negedge clk);
         t++;
      end
   endtask

   function automatic int count_und(input int d, input int lo, input int hi);
      int c = 0;
      for (int j = 0; j < nund[d] && j < UCAP; j++)
         if (und_t[d][j] > lo && und_t[d][j] <= hi) c++;
      return c;
   endfunction

   // Frame-slot model of instance A: a held sample starts a frame on the
   // edge after it arrives, but no sooner than one frame period after the
   // previous start; ready is simply "nothing held".
   task automatic run_model(input int n_cyc, input int valid_pct, input string name);
      logic [23:0] exp_f[$];
      int          exp_t[$];
      bit          m_full = 1'b0;
      logic [15:0] m_data = '0;
      int          m_free = 0;
      int          rdy_err = 0;
      int          base;
      int          t;
      rst[0] = 1'b1;
      cycles(2);
      rst[0] = 1'b0;
      base = nfrm[0];
      for (int i = 0; i < n_cyc + 300; i++) begin
         bit          v;
         logic [15:0] dv;
         v  = (i < n_cyc) && ($urandom_range(99) < valid_pct);
         dv = 16'($urandom);
         valid[0] = v;
         data_a   = dv;
         if (ready[0] !== !m_full) rdy_err++;
         t = cyc + 1;
         if (m_full && t >= m_free) begin
            exp_f.push_back({8'h30, m_data});
            exp_t.push_back(t);
            m_full = 1'b0;
            m_free = t + 48 * D_A + G_A + 1;
         end else if (v && !m_full) begin
            m_full = 1'b1;
            m_data = dv;
         end
         @(negedge clk);
      end
      valid[0] = 1'b0;
      check({name, "_ready"}, rdy_err, 0);
      check({name, "_count"}, nfrm[0] - base, exp_f.size());
      for (int i = 0; i < exp_f.size() && base + i < CAP; i++) begin
         check({name, "_frame"}, frm[0][base + i], exp_f[i]);
         check({name, "_start"}, ffall[0][base + i], exp_t[i]);
      end
   endtask

   // ------------------------------------------------------------------ tests
   typedef struct {
      int          d;
      logic [15:0] data;
      logic [23:0] frame;
      int          low;
      int          gap;
   } vec_t;

   initial begin
      vec_t        vt [4];
      logic [23:0] b2b_exp [3];
      int          base, ubase, fbase;
      int          t;

      vt[0] = '{0, 16'hA5C3, 24'h30A5C3, 48 * D_A, G_A};
      vt[1] = '{0, 16'h5A3C, 24'h305A3C, 48 * D_A, G_A};
      vt[2] = '{1, 16'h0001, 24'h300001, 48 * D_B, G_B};
      vt[3] = '{1, 16'hFFFE, 24'h30FFFE, 48 * D_B, G_B};
      b2b_exp[0] = 24'h300000;
      b2b_exp[1] = 24'h30FFFF;
      b2b_exp[2] = 24'h308000;

      rst    = 2'b11;
      valid  = 2'b00;
      data_a = '0;
      data_b = '0;
      cycles(4);

      // Reset values on both instances.
      for (int k = 0; k < 2; k++) begin
         check("rst_cs_n",     32'(cs_n[k]),     32'd1);
         check("rst_sclk",     32'(sclk[k]),     32'd0);
         check("rst_mosi",     32'(mosi[k]),     32'd0);
         check("rst_ready",    32'(ready[k]),    32'd1);
         check("rst_busy",     32'(busy[k]),     32'd0);
         check("rst_underrun", 32'(underrun[k]), 32'd0);
      end
      rst = 2'b00;

      // Quiet for 200 cycles with no valid.
      fbase = nfall[0];
      base  = nfall[1];
      cycles(200);
      check("idle_no_cs_a", nfall[0] - fbase, 0);
      check("idle_no_cs_b", nfall[1] - base, 0);

      // Single frames, table-driven.
      foreach (vt[i]) begin
         base  = nfrm[vt[i].d];
         ubase = nund[vt[i].d];
         send(vt[i].d, vt[i].data);
         wait_frames(vt[i].d, base + 1);
         cycles(10);
         check("single_count",   nfrm[vt[i].d] - base, 1);
         check("single_frame",   frm[vt[i].d][base], vt[i].frame);
         check("single_bits",    fbits[vt[i].d][base], 24);
         check("single_cs_low",  frise[vt[i].d][base] - ffall[vt[i].d][base], vt[i].low);
         check("single_busy",    busy_len[vt[i].d], vt[i].low + vt[i].gap);
         check("single_und_cnt", nund[vt[i].d] - ubase, 1);
         check("single_und_dly", und_t[vt[i].d][ubase] - frise[vt[i].d][base], vt[i].gap);
         check("single_ready",   32'(ready[vt[i].d]), 32'd1);
      end

      // Back-to-back on A: each sample offered as soon as ready rises.
      base = nfrm[0];
      send(0, 16'h0000);
      send(0, 16'hFFFF);
      send(0, 16'h8000);
      wait_frames(0, base + 3);
      cycles(10);
      check("b2b_count", nfrm[0] - base, 3);
      for (int i = 0; i < 3; i++) check("b2b_frame", frm[0][base + i], b2b_exp[i]);
      check("b2b_spacing_1", ffall[0][base + 1] - ffall[0][base], 48 * D_A + G_A + 1);
      check("b2b_spacing_2", ffall[0][base + 2] - ffall[0][base + 1], 48 * D_A + G_A + 1);
      check("b2b_early_und", count_und(0, ffall[0][base], frise[0][base + 2]), 0);
      check("b2b_final_und", count_und(0, frise[0][base + 2], cyc), 1);

      // Reset at the 10th rising SCLK edge with a second sample held.
      send(0, 16'h1234);
      send(0, 16'hBEEF);
      t = 0;
      while (cur_bits[0] < 10 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("rstmid_edge10", cur_bits[0], 10);
      ubase  = nund[0];
      rst[0] = 1'b1;
      @(negedge clk);
      check("rstmid_cs_n",  32'(cs_n[0]),  32'd1);
      check("rstmid_sclk",  32'(sclk[0]),  32'd0);
      check("rstmid_mosi",  32'(mosi[0]),  32'd0);
      check("rstmid_ready", 32'(ready[0]), 32'd1);
      check("rstmid_busy",  32'(busy[0]),  32'd0);
      @(negedge clk);
      rst[0] = 1'b0;
      fbase  = nfall[0];
      cycles(200);
      check("rstmid_no_frame", nfall[0] - fbase, 0);
      check("rstmid_no_und",   nund[0] - ubase, 0);
      base = nfrm[0];
      send(0, 16'h6789);
      wait_frames(0, base + 1);
      check("rstmid_new_frame", frm[0][base], 24'h306789);

      // Boundary instance B back to back: 50-cycle frame spacing.
      base = nfrm[1];
      send(1, 16'h0001);
      send(1, 16'h8001);
      wait_frames(1, base + 2);
      cycles(5);
      check("bnd_count",   nfrm[1] - base, 2);
      check("bnd_frame_1", frm[1][base], 24'h300001);
      check("bnd_last_bit", 32'(frm[1][base][0]), 32'd1);
      check("bnd_frame_2", frm[1][base + 1], 24'h308001);
      check("bnd_spacing", ffall[1][base + 1] - ffall[1][base], 48 * D_B + G_B + 1);

      // Randomised traffic and continuous backpressure on A.
      run_model(1200, 40, "rand");
      run_model(600, 100, "bp");

      check("protocol_a", viol[0], 0);
      check("protocol_b", viol[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, expected finish within 200000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
